instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 107 ++++++++++
 tb/tb_instr_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: FETCH/EXEC1/EXEC2/HALT control, program counter,
// instruction register and retired-instruction counter. All outputs are registered.
module instr_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] instr_rdata,
  input  logic        stall,
  input  logic        sm_extra,
  input  logic        stop,
  input  logic        run,
  input  logic        pc_sload,
  input  logic        pc_cnt_en,
  input  logic [1:0]  jump_sel,
  input  logic [15:0] reg_data,
  input  logic [15:0] ram_data,
  output logic [15:0] pc,
  output logic [15:0] instruction,
  output logic [1:0]  state,
  output logic        halted,
  output logic [15:0] retired
);

  // Encoding is shared with the decoder and must not change.
  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC1 = 2'b01,
    S_EXEC2 = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_retired;
  logic        r_halted;

  logic        w_advance;
  logic        w_retire;
  logic [15:0] w_pc_next;

  // A cycle "advances" only outside HALT with neither stop nor stall pending.
  assign w_advance = (r_state != S_HALT) && !stop && !stall;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HALT: begin
        if (run) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (stop)        w_state_next = S_HALT;
        else if (!stall) w_state_next = S_EXEC1;
      end
      S_EXEC1: begin
        if (stop)          w_state_next = S_HALT;
        else if (!stall)   w_state_next = sm_extra ? S_EXEC2 : S_FETCH;
      end
      S_EXEC2: begin
        if (stop)        w_state_next = S_HALT;
        else if (!stall) w_state_next = S_FETCH;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  assign w_retire = w_advance && (w_state_next == S_FETCH) &&
                    ((r_state == S_EXEC1) || (r_state == S_EXEC2));

  always_comb begin
    w_pc_next = r_pc;
    if (w_advance) begin
      if (pc_sload && (jump_sel != 2'b11)) begin
        case (jump_sel)
          2'b00:   w_pc_next = reg_data;
          2'b01:   w_pc_next = {4'h0, r_ir[11:0]};
          default: w_pc_next = ram_data;
        endcase
      end else if (pc_cnt_en) begin
        w_pc_next = r_pc + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_pc      <= 16'h0000;
      r_ir      <= 16'h0000;
      r_retired <= 16'h0000;
      r_halted  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_halted <= (w_state_next == S_HALT);
      if (w_advance && (r_state == S_FETCH)) r_ir <= instr_rdata;
      if (w_retire) r_retired <= r_retired + 16'd1;
    end
  end

  assign pc          = r_pc;
  assign instruction = r_ir;
  assign state       = r_state;
  assign halted      = r_halted;
  assign retired     = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer: hand-computed expectations per edge.
module tb_instr_sequencer;

  logic        clock;
  logic        reset_n;
  logic [15:0] instr_rdata;
  logic        stall;
  logic        sm_extra;
  logic        stop;
  logic        run;
  logic        pc_sload;
  logic        pc_cnt_en;
  logic [1:0]  jump_sel;
  logic [15:0] reg_data;
  logic [15:0] ram_data;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] FETCH = 2'b00;
  localparam logic [1:0] EXEC1 = 2'b01;
  localparam logic [1:0] EXEC2 = 2'b10;
  localparam logic [1:0] HALT  = 2'b11;

  instr_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_rdata (instr_rdata),
    .stall       (stall),
    .sm_extra    (sm_extra),
    .stop        (stop),
    .run         (run),
    .pc_sload    (pc_sload),
    .pc_cnt_en   (pc_cnt_en),
    .jump_sel    (jump_sel),
    .reg_data    (reg_data),
    .ram_data    (ram_data),
    .pc          (pc),
    .instruction (instruction),
    .state       (state),
    .halted      (halted),
    .retired     (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [1:0] st, input logic [15:0] p,
                            input logic [15:0] ir, input logic [15:0] ret, input logic h);
    check_eq({tag, ".state"},   {14'h0, state}, {14'h0, st});
    check_eq({tag, ".pc"},      pc, p);
    check_eq({tag, ".instr"},   instruction, ir);
    check_eq({tag, ".retired"}, retired, ret);
    check_eq({tag, ".halted"},  {15'h0, halted}, {15'h0, h});
    $display("txn %-12s state=%0d pc=%04h ir=%04h retired=%04h halted=%0d",
             tag, state, pc, instruction, retired, halted);
  endtask

  task automatic idle_inputs();
    stall = 0; sm_extra = 0; stop = 0; run = 0;
    pc_sload = 0; pc_cnt_en = 0; jump_sel = 2'b11;
  endtask

  initial begin
    idle_inputs();
    reset_n = 0; instr_rdata = 16'h0000; reg_data = 16'h0000; ram_data = 16'h0000;

    // Reset with stop/run/count active must still land in clean FETCH.
    stop = 1; run = 1; pc_cnt_en = 1;
    tick(); tick();
    expect_all("reset", FETCH, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    // Basic sequencing with count every cycle.
    idle_inputs();
    reset_n = 1; instr_rdata = 16'h4123; pc_cnt_en = 1;
    tick(); expect_all("seq.e1", EXEC1, 16'h0001, 16'h4123, 16'h0000, 1'b0);
    tick(); expect_all("seq.f",  FETCH, 16'h0002, 16'h4123, 16'h0001, 1'b0);

    // Stall held in EXEC1 with sm_extra pending.
    pc_cnt_en = 0; instr_rdata = 16'hC0A5;
    tick(); expect_all("st.e1", EXEC1, 16'h0002, 16'hC0A5, 16'h0001, 1'b0);
    sm_extra = 1; stall = 1; pc_cnt_en = 1; instr_rdata = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_all("st.hold", EXEC1, 16'h0002, 16'hC0A5, 16'h0001, 1'b0);
    end
    stall = 0; pc_cnt_en = 0;
    tick(); expect_all("st.e2", EXEC2, 16'h0002, 16'hC0A5, 16'h0001, 1'b0);
    sm_extra = 0;
    tick(); expect_all("st.f",  FETCH, 16'h0002, 16'hC0A5, 16'h0002, 1'b0);

    // Jump sources: jmd target comes from IR (0xC0A5), not instr_rdata.
    instr_rdata = 16'hC0A5;
    tick(); expect_all("j.e1", EXEC1, 16'h0002, 16'hC0A5, 16'h0002, 1'b0);
    instr_rdata = 16'h0FFF;
    pc_sload = 1; jump_sel = 2'b01; pc_cnt_en = 1;
    tick(); expect_all("j.jmd", FETCH, 16'h00A5, 16'hC0A5, 16'h0003, 1'b0);
    jump_sel = 2'b10; ram_data = 16'h1234;
    tick(); expect_all("j.rtn", EXEC1, 16'h1234, 16'h0FFF, 16'h0003, 1'b0);
    jump_sel = 2'b11;
    tick(); expect_all("j.none", FETCH, 16'h1235, 16'h0FFF, 16'h0004, 1'b0);

    // PC wrap: jmr to 0xFFFF, then count.
    jump_sel = 2'b00; reg_data = 16'hFFFF; pc_cnt_en = 1;
    tick(); expect_all("w.jmr", EXEC1, 16'hFFFF, 16'h0FFF, 16'h0004, 1'b0);
    pc_sload = 0;
    tick(); expect_all("w.wrap", FETCH, 16'h0000, 16'h0FFF, 16'h0005, 1'b0);
    pc_cnt_en = 0;
    tick(); expect_all("w.e1", EXEC1, 16'h0000, 16'h0FFF, 16'h0005, 1'b0);

    // stop beats stall and count; HALT ignores everything but run.
    stop = 1; stall = 1; pc_cnt_en = 1; sm_extra = 1;
    tick(); expect_all("h.enter", HALT, 16'h0000, 16'h0FFF, 16'h0005, 1'b1);
    stop = 0; stall = 0; pc_sload = 1; jump_sel = 2'b00; reg_data = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      stop = (i == 2); stall = (i == 3);
      tick(); expect_all("h.hold", HALT, 16'h0000, 16'h0FFF, 16'h0005, 1'b1);
    end
    idle_inputs(); run = 1; pc_cnt_en = 1;
    tick(); expect_all("h.run", FETCH, 16'h0000, 16'h0FFF, 16'h0005, 1'b0);

    // Reset mid-EXEC2 with pc=0x0042.
    idle_inputs(); pc_sload = 1; jump_sel = 2'b00; reg_data = 16'h0042; instr_rdata = 16'h1111;
    tick(); expect_all("r.e1", EXEC1, 16'h0042, 16'h1111, 16'h0005, 1'b0);
    idle_inputs(); sm_extra = 1;
    tick(); expect_all("r.e2", EXEC2, 16'h0042, 16'h1111, 16'h0005, 1'b0);
    reset_n = 0; stop = 1; run = 1; pc_cnt_en = 1;
    tick(); expect_all("r.rst", FETCH, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    // First edge after release is a plain FETCH edge.
    idle_inputs(); reset_n = 1; instr_rdata = 16'h2468;
    tick(); expect_all("r.rel", EXEC1, 16'h0000, 16'h2468, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
